// File: rtl/cpu_pkg.sv
// Shared core package: ab_op field positions, address-path encodings and
// the high-byte adjust helper used by the address bus generator.
package cpu_pkg;

  // Bit positions of each field inside the 12-bit ab_op word
  localparam int AB_CI   = 0;
  localparam int AB_LOP  = 1;
  localparam int AB_LSEL = 3;
  localparam int AB_HOP  = 5;
  localparam int AB_IPH  = 9;

  // Low-byte base select (abl_op)
  typedef enum logic [1:0] {
    ABL_REG = 2'b00,
    ABL_DB  = 2'b01,
    ABL_PC  = 2'b10,
    ABL_AB  = 2'b11
  } abl_base_e;

  // Low-byte addend select (abl_sel)
  typedef enum logic [1:0] {
    ADD_0   = 2'b00,
    ADD_REG = 2'b01,
    ADD_DB  = 2'b10,
    ADD_FF  = 2'b11
  } abl_add_e;

  // High-byte base select (abh_op[3:2])
  typedef enum logic [1:0] {
    ABH_CONST = 2'b00,
    ABH_AB    = 2'b01,
    ABH_PC    = 2'b10,
    ABH_DB    = 2'b11
  } abh_base_e;

  // High-byte modifier (abh_op[1:0]) for the constant base
  localparam logic [1:0] ABH_K00  = 2'b00;
  localparam logic [1:0] ABH_K01  = 2'b01;
  localparam logic [1:0] ABH_KRSV = 2'b10;
  localparam logic [1:0] ABH_KFF  = 2'b11;

  // High-byte modifier (abh_op[1:0]) for the non-constant bases
  localparam logic [1:0] ABH_CO   = 2'b10;
  localparam logic [1:0] ABH_COFF = 2'b11;

  // PC update (iph[1:0]) and save flag position (iph[2])
  typedef enum logic [1:0] {
    IPH_HOLD  = 2'b00,
    IPH_HOLD1 = 2'b01,
    IPH_LOAD  = 2'b10,
    IPH_INC   = 2'b11
  } iph_e;
  localparam int IPH_SAVE = 2;

  // Adding FF on top of the carry gives base-1+co, i.e. the backward
  // branch page fix: co=1 keeps the page, co=0 steps one page back.
  function automatic logic [7:0] abh_fix(input logic [7:0] base,
                                         input logic [1:0] mode,
                                         input logic       co);
    case (mode)
      ABH_CO:   return base + {7'd0, co};
      ABH_COFF: return base + {7'd0, co} + 8'hFF;
      default:  return base;
    endcase
  endfunction

endpackage

// File: rtl/ab_low.sv
// Low address byte: base/addend muxes and 9-bit adder producing the next
// low byte and the carry consumed by the high-byte logic in the same cycle.
module ab_low
  import cpu_pkg::*;
(
  input  logic [1:0] abl_op,
  input  logic [1:0] abl_sel,
  input  logic       abl_ci,
  input  logic [7:0] db,
  input  logic [7:0] reg_val,
  input  logic [7:0] pc_lo,
  input  logic [7:0] ab_lo,
  output logic [7:0] abl_next,
  output logic       co
);

  logic [7:0] base;
  logic [7:0] addend;
  logic [8:0] lo9;

  // Select base and addend, then form the 9-bit sum
  always_comb begin
    base   = 8'h00;
    addend = 8'h00;
    case (abl_op)
      ABL_REG: base = reg_val;
      ABL_DB:  base = db;
      ABL_PC:  base = pc_lo;
      default: base = ab_lo;
    endcase
    case (abl_sel)
      ADD_0:   addend = 8'h00;
      ADD_REG: addend = reg_val;
      ADD_DB:  addend = db;
      default: addend = 8'hFF;
    endcase
    lo9      = {1'b0, base} + {1'b0, addend} + {8'd0, abl_ci};
    abl_next = lo9[7:0];
    co       = lo9[8];
  end

endmodule

// File: rtl/ab_gen.sv
// Address bus generator: registered AB, PC and PC save latch driven by the
// sequencer's expanded address op word. One cycle of latency, no
// combinational path from ab_op to the outputs.
// Optional build macro AB_RDY_EN adds the RDY stall input.
module ab_gen
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_AB = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] ab_op,
  input  logic [7:0]  DB,
  input  logic [7:0]  REG,
`ifdef AB_RDY_EN
  input  logic        RDY,
`endif
  output logic [15:0] AB,
  output logic [15:0] PC,
  output logic [15:0] PCSAVE
);

  logic [2:0]  iph;
  logic [3:0]  abh_op;
  logic [1:0]  abl_sel;
  logic [1:0]  abl_op;
  logic        abl_ci;
  logic [7:0]  abl_next;
  logic        co;
  logic [7:0]  abh_next;
  logic        rsv;
  logic [15:0] ab_next;
  logic [15:0] pc_next;
  logic        en;

  assign iph     = ab_op[AB_IPH +: 3];
  assign abh_op  = ab_op[AB_HOP +: 4];
  assign abl_sel = ab_op[AB_LSEL +: 2];
  assign abl_op  = ab_op[AB_LOP +: 2];
  assign abl_ci  = ab_op[AB_CI];

`ifdef AB_RDY_EN
  assign en = RDY;
`else
  assign en = 1'b1;
`endif

  ab_low u_low (
    .abl_op   (abl_op),
    .abl_sel  (abl_sel),
    .abl_ci   (abl_ci),
    .db       (DB),
    .reg_val  (REG),
    .pc_lo    (PC[7:0]),
    .ab_lo    (AB[7:0]),
    .abl_next (abl_next),
    .co       (co)
  );

  // High byte select and adjust; flag the reserved constant encoding
  always_comb begin
    abh_next = 8'h00;
    rsv      = 1'b0;
    case (abh_op[3:2])
      ABH_CONST: begin
        case (abh_op[1:0])
          ABH_K00: abh_next = 8'h00;
          ABH_K01: abh_next = 8'h01;
          ABH_KFF: abh_next = 8'hFF;
          default: begin
            abh_next = 8'hxx;
            rsv      = 1'b1;
          end
        endcase
      end
      ABH_AB:  abh_next = abh_fix(AB[15:8], abh_op[1:0], co);
      ABH_PC:  abh_next = abh_fix(PC[15:8], abh_op[1:0], co);
      default: abh_next = abh_fix(DB, abh_op[1:0], co);
    endcase
  end

  assign ab_next = {abh_next, abl_next};

  // Next PC; a reserved high encoding leaves PC alone so x never reaches it
  always_comb begin
    pc_next = PC;
    if (!rsv) begin
      case (iph[1:0])
        IPH_LOAD: pc_next = ab_next;
        IPH_INC:  pc_next = ab_next + 16'd1;
        default:  pc_next = PC;
      endcase
    end
  end

  // Register AB, PC and the save latch; reset wins over the stall
  always_ff @(posedge clk) begin
    if (reset) begin
      AB     <= RESET_AB;
      PC     <= RESET_AB;
      PCSAVE <= 16'h0000;
    end else if (en) begin
      AB <= ab_next;
      PC <= pc_next;
      if (iph[IPH_SAVE] && !rsv) PCSAVE <= pc_next;
    end
  end

endmodule

// File: tb/tb_ab_gen.sv
// Directed bench for ab_gen built with RESET_AB = 16'hFFFC.
// Define AB_RDY_EN to include the RDY stall scenario.
module tb_ab_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] ab_op = 12'h000;
  logic [7:0]  db = 8'h00;
  logic [7:0]  rg = 8'h00;
`ifdef AB_RDY_EN
  logic        rdy = 1'b1;
`endif
  logic [15:0] ab;
  logic [15:0] pc;
  logic [15:0] pcsave;

  int checks = 0;
  int errors = 0;

  ab_gen #(.RESET_AB(16'hFFFC)) dut (
    .clk    (clk),
    .reset  (reset),
    .ab_op  (ab_op),
    .DB     (db),
    .REG    (rg),
`ifdef AB_RDY_EN
    .RDY    (rdy),
`endif
    .AB     (ab),
    .PC     (pc),
    .PCSAVE (pcsave)
  );

  always #5 clk = ~clk;

  // Apply one op and sample 1 time unit after the capturing edge
  task automatic step(input logic [11:0] op, input logic [7:0] d, input logic [7:0] r);
    ab_op = op;
    db    = d;
    rg    = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step({3'b111, 4'b1010, 2'b10, 2'b01, 1'b1}, 8'h5A, 8'hA5);
    step({3'b011, 4'b0111, 2'b11, 2'b11, 1'b1}, 8'h33, 8'h44);
    checks++;
    if ({ab, pc, pcsave} !== {16'hFFFC, 16'hFFFC, 16'h0000}) begin
      $display("FAIL reset ab/pc/pcsave got %h %h %h want fffc fffc 0000", ab, pc, pcsave);
      errors++;
    end
    reset = 1'b0;
  endtask

  task automatic test_fetch;
    // AB = DB:DB, then load low byte from DB keeping AB high, PC <= AB
    step({3'b000, 4'b1100, 2'b00, 2'b01, 1'b0}, 8'h12, 8'h00);
    checks++;
    if ({ab, pc} !== {16'h1212, 16'hFFFC}) begin
      $display("FAIL fetch_setup1 ab/pc got %h %h want 1212 fffc", ab, pc);
      errors++;
    end
    step({3'b010, 4'b0100, 2'b00, 2'b01, 1'b0}, 8'hFF, 8'h00);
    checks++;
    if ({ab, pc} !== {16'h12FF, 16'h12FF}) begin
      $display("FAIL fetch_load ab/pc got %h %h want 12ff 12ff", ab, pc);
      errors++;
    end
    step({3'b011, 4'b1010, 2'b00, 2'b10, 1'b1}, 8'h00, 8'h00);
    checks++;
    if ({ab, pc} !== {16'h1300, 16'h1301}) begin
      $display("FAIL fetch_carry ab/pc got %h %h want 1300 1301", ab, pc);
      errors++;
    end
  endtask

  task automatic test_indexed;
    step({3'b000, 4'b1100, 2'b00, 2'b01, 1'b0}, 8'h40, 8'h00);
    step({3'b000, 4'b0100, 2'b00, 2'b01, 1'b0}, 8'hF0, 8'h00);
    checks++;
    if (ab !== 16'h40F0) begin
      $display("FAIL indexed_setup ab got %h want 40f0", ab);
      errors++;
    end
    step({3'b001, 4'b0110, 2'b01, 2'b11, 1'b0}, 8'h00, 8'h20);
    checks++;
    if ({ab, pc} !== {16'h4110, 16'h1301}) begin
      $display("FAIL indexed ab/pc got %h %h want 4110 1301", ab, pc);
      errors++;
    end
  endtask

  task automatic test_branch;
    step({3'b000, 4'b1100, 2'b00, 2'b01, 1'b0}, 8'h20, 8'h00);
    step({3'b000, 4'b0100, 2'b00, 2'b01, 1'b0}, 8'h05, 8'h00);
    checks++;
    if (ab !== 16'h2005) begin
      $display("FAIL branch_setup ab got %h want 2005", ab);
      errors++;
    end
    // co = 0: page steps back by one
    step({3'b011, 4'b0111, 2'b10, 2'b11, 1'b1}, 8'hF0, 8'h00);
    checks++;
    if ({ab, pc} !== {16'h1FF6, 16'h1FF7}) begin
      $display("FAIL branch_back ab/pc got %h %h want 1ff6 1ff7", ab, pc);
      errors++;
    end
    // co = 1: F6 + 10 + 1 = 107, page stays 1F
    step({3'b000, 4'b0111, 2'b10, 2'b11, 1'b1}, 8'h10, 8'h00);
    checks++;
    if ({ab, pc} !== {16'h1F07, 16'h1FF7}) begin
      $display("FAIL branch_same_page ab/pc got %h %h want 1f07 1ff7", ab, pc);
      errors++;
    end
  endtask

  task automatic test_push_save;
    step({3'b000, 4'b1100, 2'b00, 2'b01, 1'b0}, 8'h03, 8'h00);
    step({3'b010, 4'b0100, 2'b00, 2'b01, 1'b0}, 8'h00, 8'h00);
    checks++;
    if (pc !== 16'h0300) begin
      $display("FAIL push_setup pc got %h want 0300", pc);
      errors++;
    end
    step({3'b111, 4'b0001, 2'b00, 2'b00, 1'b0}, 8'h00, 8'hFD);
    checks++;
    if ({ab, pc, pcsave} !== {16'h01FD, 16'h01FE, 16'h01FE}) begin
      $display("FAIL push_save ab/pc/pcsave got %h %h %h want 01fd 01fe 01fe", ab, pc, pcsave);
      errors++;
    end
    // Save with plain load: DB 80 + FF -> 7F, high constant FF
    step({3'b110, 4'b0011, 2'b11, 2'b01, 1'b0}, 8'h80, 8'h00);
    checks++;
    if ({ab, pc, pcsave} !== {16'hFF7F, 16'hFF7F, 16'hFF7F}) begin
      $display("FAIL save_load ab/pc/pcsave got %h %h %h want ff7f ff7f ff7f", ab, pc, pcsave);
      errors++;
    end
  endtask

  task automatic test_wrap_and_reserved;
    step({3'b011, 4'b0011, 2'b00, 2'b01, 1'b0}, 8'hFF, 8'h00);
    checks++;
    if ({ab, pc, pcsave} !== {16'hFFFF, 16'h0000, 16'hFF7F}) begin
      $display("FAIL pc_wrap ab/pc/pcsave got %h %h %h want ffff 0000 ff7f", ab, pc, pcsave);
      errors++;
    end
    // Reserved constant high encoding with save + increment requested
    step({3'b111, 4'b0010, 2'b00, 2'b01, 1'b0}, 8'h55, 8'h00);
    checks++;
    if ({pc, pcsave} !== {16'h0000, 16'hFF7F}) begin
      $display("FAIL reserved pc/pcsave got %h %h want 0000 ff7f", pc, pcsave);
      errors++;
    end
  endtask

`ifdef AB_RDY_EN
  task automatic test_rdy;
    rdy = 1'b1;
    step({3'b000, 4'b1100, 2'b00, 2'b01, 1'b0}, 8'h34, 8'h00);
    checks++;
    if ({ab, pc} !== {16'h3434, 16'h0000}) begin
      $display("FAIL rdy_setup ab/pc got %h %h want 3434 0000", ab, pc);
      errors++;
    end
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step({3'b111, 4'b0001 + 4'(i), 2'b01, 2'b01, 1'b1}, 8'h10 + 8'(i), 8'h22);
      checks++;
      if ({ab, pc, pcsave} !== {16'h3434, 16'h0000, 16'hFF7F}) begin
        $display("FAIL rdy_hold%0d ab/pc/pcsave got %h %h %h want 3434 0000 ff7f", i, ab, pc, pcsave);
        errors++;
      end
    end
    rdy = 1'b1;
    step({3'b011, 4'b0100, 2'b00, 2'b01, 1'b0}, 8'h56, 8'h00);
    checks++;
    if ({ab, pc, pcsave} !== {16'h3456, 16'h3457, 16'hFF7F}) begin
      $display("FAIL rdy_resume ab/pc/pcsave got %h %h %h want 3456 3457 ff7f", ab, pc, pcsave);
      errors++;
    end
    rdy   = 1'b0;
    reset = 1'b1;
    step({3'b111, 4'b1010, 2'b00, 2'b10, 1'b1}, 8'h00, 8'h00);
    checks++;
    if ({ab, pc, pcsave} !== {16'hFFFC, 16'hFFFC, 16'h0000}) begin
      $display("FAIL rdy_reset ab/pc/pcsave got %h %h %h want fffc fffc 0000", ab, pc, pcsave);
      errors++;
    end
    reset = 1'b0;
    rdy   = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_indexed();
    test_branch();
    test_push_save();
    test_wrap_and_reserved();
`ifdef AB_RDY_EN
    test_rdy();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
